// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - multi-channel button debouncer with press/release one-shots
//
// Purpose: per-channel 2-flop synchroniser, shared sample-tick divider,
// stability-count debounce, and PULSE_LEN-cycle PRESS/RELEASE one-shots.
// Optional auto-repeat of PRESS while held, enabled by defining DEBOUNCE_REPEAT_EN.
//
// Ports:
//   CLK_100    in   1      system clock
//   RST        in   1      synchronous active-high reset
//   BTN        in   N_BTN  raw asynchronous buttons, 1 = pressed
//   DB_BTN     out  N_BTN  debounced level
//   PRESS      out  N_BTN  one-shot on debounced rising edge (and on repeats)
//   RELEASE    out  N_BTN  one-shot on debounced falling edge
//   ANY_PRESS  out  1      OR of PRESS

module debounce_multi #(
    parameter int N_BTN        = 5,
    parameter int TICK_DIV     = 125000,
    parameter int STABLE_CNT   = 4,
    parameter int PULSE_LEN    = 8,
    parameter int REPEAT_DELAY = 400,
    parameter int REPEAT_RATE  = 80
) (
    input  logic             CLK_100,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN,
    output logic [N_BTN-1:0] DB_BTN,
    output logic [N_BTN-1:0] PRESS,
    output logic [N_BTN-1:0] RELEASE,
    output logic             ANY_PRESS
);

    localparam int DW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);

    localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CNT - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN - 1);

    localparam bit PARAMS_OK = (N_BTN >= 1) && (N_BTN <= 32) && (TICK_DIV >= 2) &&
                               (STABLE_CNT >= 1) && (PULSE_LEN >= 1) &&
                               (PULSE_LEN < TICK_DIV) &&
                               (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("debounce_multi: illegal parameter combination");
    end

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [DW-1:0]    div_cnt;
    logic             tick;
    logic [SW-1:0]    stab   [N_BTN];
    logic [PW-1:0]    pcnt   [N_BTN];
    logic [N_BTN-1:0] db_q;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] rel_q;
    logic [N_BTN-1:0] toggle;
    logic [N_BTN-1:0] rep_fire;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge CLK_100) begin
        if (RST) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // A channel flips on the tick whose disagreement would complete STABLE_CNT.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < N_BTN; i++) begin
            toggle[i] = tick && (sync2[i] != db_q[i]) && (stab[i] == STAB_LAST);
        end
    end

    always_ff @(posedge CLK_100) begin
        if (RST) begin
            sync1   <= '0;
            sync2   <= '0;
            db_q    <= '0;
            press_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                stab[i] <= '0;
                pcnt[i] <= '0;
            end
        end else begin
            sync1 <= BTN;
            sync2 <= sync1;
            for (int i = 0; i < N_BTN; i++) begin
                if (tick) begin
                    if (sync2[i] == db_q[i] || toggle[i]) begin
                        stab[i] <= '0;
                    end else begin
                        stab[i] <= stab[i] + SW'(1);
                    end
                end
                if (toggle[i]) begin
                    db_q[i] <= ~db_q[i];
                end
                // pcnt holds remaining cycles after the current one; an edge
                // or repeat reloads it and selects which output is driven.
                if (toggle[i]) begin
                    press_q[i] <= ~db_q[i];
                    rel_q[i]   <= db_q[i];
                    pcnt[i]    <= PULSE_LOAD;
                end else if (rep_fire[i]) begin
                    press_q[i] <= 1'b1;
                    rel_q[i]   <= 1'b0;
                    pcnt[i]    <= PULSE_LOAD;
                end else if (pcnt[i] != '0) begin
                    pcnt[i] <= pcnt[i] - PW'(1);
                end else begin
                    press_q[i] <= 1'b0;
                    rel_q[i]   <= 1'b0;
                end
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);

    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0]    rep_cnt [N_BTN];
    logic [N_BTN-1:0] rep_armed;

    // First repeat waits REPEAT_DELAY held ticks; later ones REPEAT_RATE.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rep_fire[i] = tick && db_q[i] && !toggle[i] &&
                          (rep_cnt[i] == (rep_armed[i] ? RATE_LAST : DELAY_LAST));
        end
    end

    always_ff @(posedge CLK_100) begin
        if (RST) begin
            rep_armed <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (toggle[i] || !db_q[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_armed[i] <= 1'b0;
                end else if (rep_fire[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_armed[i] <= 1'b1;
                end else if (tick) begin
                    rep_cnt[i] <= rep_cnt[i] + RW'(1);
                end
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    assign DB_BTN    = db_q;
    assign PRESS     = press_q;
    assign RELEASE   = rel_q;
    assign ANY_PRESS = |press_q;

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter N_BTN, default 5: number of independent button channels, 1..32.
REQ-002 Parameter TICK_DIV, default 125000: CLK_100 cycles per sample tick (800 Hz at 100 MHz), at least 2.
REQ-003 Parameter STABLE_CNT, default 4: consecutive disagreeing sample ticks needed to change debounced level, at least 1.
REQ-004 Parameter PULSE_LEN, default 8: one-shot width in CLK_100 cycles, 1..TICK_DIV-1.
REQ-005 Parameter REPEAT_DELAY, default 400: ticks held before first auto-repeat (used only with the macro in REQ-025).
REQ-006 Parameter REPEAT_RATE, default 80: ticks between auto-repeats (used only with the macro in REQ-025).
REQ-007 CLK_100  in  1  system clock; reset RST, synchronous, active-high; clock CLK_100.
REQ-008 RST  in  1  synchronous active-high reset.
REQ-009 BTN  in  N_BTN  raw asynchronous button inputs, 1 = pressed.
REQ-010 DB_BTN  out  N_BTN  debounced level per channel.
REQ-011 PRESS  out  N_BTN  PULSE_LEN-cycle one-shot per debounced rising edge.
REQ-012 RELEASE  out  N_BTN  PULSE_LEN-cycle one-shot per debounced falling edge.
REQ-013 ANY_PRESS  out  1  OR-reduction of PRESS.

Function
REQ-014 Each BTN bit SHALL pass through a 2-flop synchroniser clocked by CLK_100; no derived or gated clocks.
REQ-015 A shared divider SHALL count 0..TICK_DIV-1 and wrap, asserting a one-cycle internal tick on count TICK_DIV-1.
REQ-016 On each tick, per channel: if synced sample equals DB_BTN, the stability counter SHALL clear; otherwise it SHALL increment.
REQ-017 When the increment would reach STABLE_CNT, DB_BTN SHALL toggle on that clock edge and the stability counter SHALL clear.
REQ-018 Worst-case press-to-DB_BTN latency SHALL be at most 2 + STABLE_CNT*TICK_DIV + 1 cycles; a bounce shorter than STABLE_CNT-1 ticks SHALL cause no DB_BTN change.
REQ-019 PRESS[i] SHALL be high for exactly PULSE_LEN cycles, starting in the first cycle DB_BTN[i] reads 1.
REQ-020 RELEASE[i] SHALL behave the same way, starting in the first cycle DB_BTN[i] reads 0 after being 1.
REQ-021 A new edge arriving while a pulse is active SHALL reload the pulse counter; PRESS and RELEASE of one channel SHALL never overlap.
REQ-022 Channels SHALL be fully independent; simultaneous edges on several channels SHALL produce concurrent pulses.
REQ-023 ANY_PRESS SHALL be combinational with zero added latency from PRESS.

Reset
REQ-024 While RST is high at a CLK_100 edge, the divider, synchronisers, stability counters, pulse counters, DB_BTN, PRESS, RELEASE and ANY_PRESS SHALL all go to 0 by the next cycle, including mid-pulse or mid-count. A button still held after reset SHALL re-debounce from scratch and produce a fresh PRESS.

Configuration
REQ-025 With DEBOUNCE_REPEAT_EN defined, each channel SHALL count ticks while DB_BTN is held. It SHALL fire an extra PRESS pulse after REPEAT_DELAY ticks, then every REPEAT_RATE ticks until release. Release SHALL clear the repeat counter.
REQ-026 With DEBOUNCE_REPEAT_EN undefined, the repeat logic SHALL be absent, the REPEAT_* parameters SHALL be ignored, and PRESS SHALL fire exactly once per debounced press.

Verification (TICK_DIV=10, STABLE_CNT=4, PULSE_LEN=8, N_BTN=4)
REQ-027 Clean press: BTN[0] rises and is held -> DB_BTN[0] rises within 43 cycles; PRESS[0] and ANY_PRESS are high for exactly 8 cycles; other channels stay 0.
REQ-028 Bounce: BTN[1] toggles every 15 cycles for 300 cycles, then holds low -> DB_BTN[1], PRESS[1] and RELEASE[1] stay 0 throughout.
REQ-029 Release: held BTN[2] falls -> DB_BTN[2] falls within 43 cycles; RELEASE[2] is high for 8 cycles; no PRESS[2] pulse occurs.
REQ-030 Simultaneous: BTN[0] and BTN[3] rise in the same cycle -> PRESS[0] and PRESS[3] assert in the same cycle, each for 8 cycles.
REQ-031 Reset mid-pulse: RST is pulsed for 1 cycle at cycle 3 of PRESS[0] while BTN[0] is held -> all outputs are 0 next cycle; DB_BTN[0] re-rises within 43 cycles with a fresh 8-cycle PRESS[0].
REQ-032 Repeat (DEBOUNCE_REPEAT_EN, REPEAT_DELAY=6, REPEAT_RATE=3): BTN[0] is held 150 cycles -> initial PRESS, then repeats 60 cycles later and every 30 cycles; without the macro, a single PRESS only.
